// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result bus for cla_seq_adder_ctrl.
// The request side is a valid/ready handshake carrying a, b, sub and c_in.
// The response side is a valid/ready handshake carrying sum, c_out and overflow.
//   master : producer/consumer side (drives requests, accepts results)
//   slave  : controller side
interface cla_seq_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Sequential add/subtract unit that time-shares one 4-bit carry-lookahead
// adder, one nibble per clock, LSB nibble first.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_io : slave side of cla_seq_adder_ctrl_if
//            in_valid/in_ready + a, b, sub, c_in     (operand request)
//            out_valid/out_ready + sum, c_out, overflow (result)
// Handshake at edge T -> RUN at edges T+1..T+NIBBLES -> out_valid from T+NIBBLES.

// 4-bit carry-lookahead adder slice.
module cla_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_i);
    s_o  = p ^ c[3:0];
    c_o  = c[4];
  end
endmodule

module cla_seq_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  cla_seq_adder_ctrl_if.slave  bus_io
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;   // already inverted for subtract
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] cla_s;
  logic       cla_c;
  logic       last_nib;
  logic       msb_cin;

  // Select the active nibble of each operand register.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  cla_4b u_cla (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (carry_q),
    .s_o (cla_s),
    .c_o (cla_c)
  );

  assign last_nib = (k_q == KW'(NIBBLES - 1));
  // Carry into the MSB, recovered from the MSB sum bit of the final nibble.
  assign msb_cin  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ cla_s[3];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          a_d     = bus_io.a;
          b_d     = bus_io.sub ? ~bus_io.b : bus_io.b;
          carry_d = bus_io.sub ? 1'b1 : bus_io.c_in;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[4*i +: 4] = cla_s;
          end
        end
        carry_d = cla_c;
        if (last_nib) begin
          c_out_d = cla_c;
          ovf_d   = msb_cin ^ cla_c;
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.sum       = sum_q;
  assign bus_io.c_out     = c_out_q;
  assign bus_io.overflow  = ovf_q;
endmodule
